regarray32: RTL and testbench
=============================

// Module: regarray32
// PURPOSE
//  32 x 32-bit general-purpose register file for the multicycle RISC-V core.
//  Every register is written from a single write bus, G (the ALU result
//  register), under a one-hot per-register enable vector from the rd decoder.
//  All 32 register values are exposed in parallel to the two operand-select
//  multiplexers.
//  Each storage element is a generic enabled register cell, regn (parameter n,
//  default 32), instantiated inside this block. r0 is hard-wired to zero.
// PARAMETERS
//  WIDTH   32   data width of G and of each register r0..r31 (also the regn cell n)
// PORTS
//  clk       input   1      rising-edge clock
//  resetn    input   1      asynchronous active-low reset
//  G         input   WIDTH  write-data bus (value to store)
//  R_in      input   32     per-register write enables; bit i targets register ri
//  r0..r31   output  WIDTH  each; current contents of registers 0..31
// BEHAVIOUR
//  Clock and reset (already decided):
//  - One clock, clk. Reset is asynchronous and active-low on resetn.
//  - While resetn = 0, all r1..r31 read 0 immediately, independent of clk.
//  - An edge coinciding with reset does not load.
//  Write:
//  - On a rising clk edge with resetn = 1, every ri (i = 1..31) with R_in[i] = 1 loads G.
//  - A register with R_in[i] = 0 holds its value.
//  - Several enable bits set in the same cycle: all selected registers load the same G.
//    No priority is applied and no error is raised.
//  - R_in = 0: no register changes.
//  - Write latency is 1 clock. A new value is visible on ri right after the loading edge.
//  - Write-then-read in the same cycle returns the OLD value. There is no bypass.
//  Read:
//  - Outputs are register Q outputs. There is no combinational path from G or R_in to any ri.
//  Register 0:
//  - r0 is constant 0 at all times. R_in[0] is ignored.
//  - The store path uses rs2 + r0 as the data, so r0 must never change.
//  Cell regn (parameter n, default 32):
//  - Ports: D[n-1:0], resetn, En, clk, Q[n-1:0].
//  - Q clears asynchronously when resetn = 0.
//  - Otherwise Q <= D on a rising clk edge if En = 1, else Q holds.
//  - The same cell is reused elsewhere for the IR, G, ADDR, dout, the 3-bit flag register and the 1-bit W register.
//  Reset mid-operation:
//  - Asserting resetn between edges clears r1..r31 immediately.
//  - The first rising edge with resetn = 1 may load normally.
// TESTING
//  1. Reset: set resetn=0 with no clock edge -> r0..r31 = 0 at once.
//     Release reset, keep R_in=0, apply 3 edges -> all registers still 0.
//  2. Single write: G=32'hDEADBEEF, R_in=32'h0000_0020, one edge -> r5=DEADBEEF, all others 0.
//     Next edge with R_in=0 -> r5 holds.
//  3. Register 0: G=32'hFFFF_FFFF, R_in=32'h0000_0001, one edge -> r0=0, all others unchanged.
//  4. Multi-enable: G=32'h1234_5678, R_in=32'h8000_0006, one edge -> r1=r2=r31=12345678.
//  5. Sweep: for i=1..31 write G=i*32'h0101_0101 with R_in=1<<i -> each ri matches.
//     Each ri changes only on its own write edge; the value present before that edge is the old one.
//  6. Async reset mid-run: with registers loaded, pulse resetn low between edges -> all 0 immediately.
//     Then write r7=32'hA5A5A5A5 on the next edge -> r7=A5A5A5A5.

Source files
------------

// File: rtl/regarray32.sv
// regarray32 -- 32 x WIDTH general-purpose register file.
//
// Every register r1..r31 loads the shared write bus G on a rising clk edge
// when its bit of the one-hot write-enable vector R_in is set. Several bits
// may be set at once; every selected register then loads the same value.
// r0 is a constant zero and R_in[0] has no effect. Outputs come straight
// from register state: a write becomes visible only after its loading edge.
//
// Ports:
//   clk       rising-edge clock
//   resetn    asynchronous active-low reset, clears r1..r31
//   G         write-data bus
//   R_in      per-register write enables, bit i targets ri
//   r0..r31   current register contents

// regn -- generic enabled register cell with asynchronous active-low clear.
//
// Ports:
//   D       data input
//   resetn  asynchronous active-low clear
//   En      load enable
//   clk     rising-edge clock
//   Q       stored value
module regn #(
    parameter int unsigned n = 32
) (
    input  logic [n-1:0] D,
    input  logic         resetn,
    input  logic         En,
    input  logic         clk,
    output logic [n-1:0] Q
);

    logic [n-1:0] q_d;
    logic [n-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (En) begin
            q_d = D;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

module regarray32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] G,
    input  logic [31:0]      R_in,
    output logic [WIDTH-1:0] r0,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] r3,
    output logic [WIDTH-1:0] r4,
    output logic [WIDTH-1:0] r5,
    output logic [WIDTH-1:0] r6,
    output logic [WIDTH-1:0] r7,
    output logic [WIDTH-1:0] r8,
    output logic [WIDTH-1:0] r9,
    output logic [WIDTH-1:0] r10,
    output logic [WIDTH-1:0] r11,
    output logic [WIDTH-1:0] r12,
    output logic [WIDTH-1:0] r13,
    output logic [WIDTH-1:0] r14,
    output logic [WIDTH-1:0] r15,
    output logic [WIDTH-1:0] r16,
    output logic [WIDTH-1:0] r17,
    output logic [WIDTH-1:0] r18,
    output logic [WIDTH-1:0] r19,
    output logic [WIDTH-1:0] r20,
    output logic [WIDTH-1:0] r21,
    output logic [WIDTH-1:0] r22,
    output logic [WIDTH-1:0] r23,
    output logic [WIDTH-1:0] r24,
    output logic [WIDTH-1:0] r25,
    output logic [WIDTH-1:0] r26,
    output logic [WIDTH-1:0] r27,
    output logic [WIDTH-1:0] r28,
    output logic [WIDTH-1:0] r29,
    output logic [WIDTH-1:0] r30,
    output logic [WIDTH-1:0] r31
);

    logic [WIDTH-1:0] regs [32];

    // r0 has no storage cell: the store path adds r0 to rs2, so it must
    // read zero even when R_in[0] is asserted.
    assign regs[0] = '0;

    logic unused_r_in0;
    assign unused_r_in0 = R_in[0];

    for (genvar i = 1; i < 32; i++) begin : g_reg
        regn #(
            .n(WIDTH)
        ) u_reg (
            .D      (G),
            .resetn (resetn),
            .En     (R_in[i]),
            .clk    (clk),
            .Q      (regs[i])
        );
    end

    assign r0  = regs[0];
    assign r1  = regs[1];
    assign r2  = regs[2];
    assign r3  = regs[3];
    assign r4  = regs[4];
    assign r5  = regs[5];
    assign r6  = regs[6];
    assign r7  = regs[7];
    assign r8  = regs[8];
    assign r9  = regs[9];
    assign r10 = regs[10];
    assign r11 = regs[11];
    assign r12 = regs[12];
    assign r13 = regs[13];
    assign r14 = regs[14];
    assign r15 = regs[15];
    assign r16 = regs[16];
    assign r17 = regs[17];
    assign r18 = regs[18];
    assign r19 = regs[19];
    assign r20 = regs[20];
    assign r21 = regs[21];
    assign r22 = regs[22];
    assign r23 = regs[23];
    assign r24 = regs[24];
    assign r25 = regs[25];
    assign r26 = regs[26];
    assign r27 = regs[27];
    assign r28 = regs[28];
    assign r29 = regs[29];
    assign r30 = regs[30];
    assign r31 = regs[31];

endmodule

// File: tb/tb_regarray32.sv
// Testbench for regarray32: a reference model of the 32 registers produces
// expected values that are queued when stimulus is applied and popped and
// compared against the DUT outputs once they are sampled.
module tb_regarray32;

    logic        clk    = 1'b0;
    logic        resetn = 1'b1;
    logic [31:0] G      = '0;
    logic [31:0] R_in   = '0;
    logic [31:0] rv [32];

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0] model [32];

    typedef struct {
        logic [31:0] value;
        int unsigned idx;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    regarray32 #(
        .WIDTH(32)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .G      (G),
        .R_in   (R_in),
        .r0     (rv[0]),
        .r1     (rv[1]),
        .r2     (rv[2]),
        .r3     (rv[3]),
        .r4     (rv[4]),
        .r5     (rv[5]),
        .r6     (rv[6]),
        .r7     (rv[7]),
        .r8     (rv[8]),
        .r9     (rv[9]),
        .r10    (rv[10]),
        .r11    (rv[11]),
        .r12    (rv[12]),
        .r13    (rv[13]),
        .r14    (rv[14]),
        .r15    (rv[15]),
        .r16    (rv[16]),
        .r17    (rv[17]),
        .r18    (rv[18]),
        .r19    (rv[19]),
        .r20    (rv[20]),
        .r21    (rv[21]),
        .r22    (rv[22]),
        .r23    (rv[23]),
        .r24    (rv[24]),
        .r25    (rv[25]),
        .r26    (rv[26]),
        .r27    (rv[27]),
        .r28    (rv[28]),
        .r29    (rv[29]),
        .r30    (rv[30]),
        .r31    (rv[31])
    );

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic push_model();
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back('{value: model[i], idx: i});
        end
    endtask

    task automatic drain(input string tag);
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s_r%0d", tag, e.idx), rv[e.idx], e.value);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            model[i] = '0;
        end
    endtask

    // Called shortly after a rising edge. Checks that nothing has changed
    // before the edge, then that exactly the enabled registers (except r0)
    // took G after it.
    task automatic write_cycle(input logic [31:0] g, input logic [31:0] en,
                               input string tag);
        G    = g;
        R_in = en;
        push_model();
        #1;
        drain({tag, "_pre"});
        @(posedge clk);
        for (int i = 1; i < 32; i++) begin
            if (en[i]) begin
                model[i] = g;
            end
        end
        push_model();
        #1;
        drain(tag);
        R_in = '0;
    endtask

    initial begin
        model_clear();

        // Asynchronous reset before any clock edge.
        #1 resetn = 1'b0;
        #1;
        push_model();
        drain("rst_async");

        // An edge while reset is held must not load.
        G    = 32'hFFFF_FFFF;
        R_in = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        push_model();
        drain("rst_edge");
        G      = '0;
        R_in   = '0;
        resetn = 1'b1;

        for (int k = 0; k < 3; k++) begin
            write_cycle(32'h0000_0000, 32'h0000_0000, "idle");
        end

        write_cycle(32'hDEAD_BEEF, 32'h0000_0020, "single");
        write_cycle(32'h0BAD_F00D, 32'h0000_0000, "hold");
        write_cycle(32'hFFFF_FFFF, 32'h0000_0001, "r0_write");
        write_cycle(32'h1234_5678, 32'h8000_0006, "multi");

        for (int unsigned i = 1; i < 32; i++) begin
            write_cycle(i * 32'h0101_0101, 32'h1 << i, $sformatf("sweep%0d", i));
        end

        // Reset pulse between edges, then a write on the following edge.
        resetn = 1'b0;
        model_clear();
        #1;
        push_model();
        drain("mid_rst");
        resetn = 1'b1;
        #1;
        write_cycle(32'hA5A5_A5A5, 32'h0000_0080, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
